unidad_control: RTL and testbench

Multi-cycle control unit that sequences the `Procesador` datapath. It fetches 16-bit instruction words from an asynchronous program ROM and decodes them. Each cycle it drives the datapath control word (`A_sel`…`Load_en`), handshakes data-memory reads and writes, and latches the datapath `Tags` for conditional branches. It sits between the program ROM, the data memory and one `Procesador` instance.

---
 rtl/unidad_control_pkg.sv | 68 ++++++
 rtl/unidad_control_decodificador_instr.sv | 71 +++++++
 rtl/unidad_control.sv | 143 ++++++++++++++
 tb/tb_unidad_control.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidad_control_pkg.sv
// unidad_control_pkg: shared types for the Procesador control unit.
// Opcodes, FSM states, IR field positions, Tags indices, control word.
package unidad_control_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_OPR  = 4'h1,
        OP_OPI  = 4'h2,
        OP_SHF  = 4'h3,
        OP_LD   = 4'h4,
        OP_ST   = 4'h5,
        OP_JMP  = 4'h6,
        OP_BRC  = 4'h7,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_K,
        S_EXEC,
        S_MEM
    } state_t;

    localparam int IR_OP_HI = 15;
    localparam int IR_OP_LO = 12;
    localparam int IR_RD_HI = 11;
    localparam int IR_RD_LO = 10;
    localparam int IR_RA_HI = 9;
    localparam int IR_RA_LO = 8;
    localparam int IR_RB_HI = 7;
    localparam int IR_RB_LO = 6;
    localparam int IR_FN_HI = 5;
    localparam int IR_FN_LO = 2;
    localparam int IR_SH_HI = 3;
    localparam int IR_SH_LO = 2;

    localparam int TAG_Z = 0;
    localparam int TAG_N = 1;
    localparam int TAG_C = 2;
    localparam int TAG_V = 3;

    typedef struct packed {
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [1:0] d_sel;
        logic [1:0] h_sel;
        logic [3:0] g_sel;
        logic       mb_sel;
        logic       md_sel;
        logic       mf_sel;
        logic [3:0] load_en;
        logic       mem_req;
        logic       mem_we;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '0;

    function automatic logic [3:0] onehot(input logic [1:0] r);
        return 4'b0001 << r;
    endfunction

    // 8..E are unassigned; F is HALT.
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3] && (op != 4'hF);
    endfunction

endpackage

// File: rtl/unidad_control_decodificador_instr.sv
// decodificador_instr: combinational control-word decode from (state, IR, K).
// Ports: state, ir, k in; ctrl (selects, load_en, mem_req/we), cons out.
module decodificador_instr
    import unidad_control_pkg::*;
#(
    parameter int m = 8
) (
    input  state_t         state,
    input  logic [15:0]    ir,
    input  logic [m-1:0]   k,
    output ctrl_t          ctrl,
    output logic [m-1:0]   cons
);

    opcode_t    op;
    logic [1:0] rd, ra, rb, sh;
    logic [3:0] fn;
    logic       unused_rsv;

    assign op = opcode_t'(ir[IR_OP_HI:IR_OP_LO]);
    assign rd = ir[IR_RD_HI:IR_RD_LO];
    assign ra = ir[IR_RA_HI:IR_RA_LO];
    assign rb = ir[IR_RB_HI:IR_RB_LO];
    assign fn = ir[IR_FN_HI:IR_FN_LO];
    assign sh = ir[IR_SH_HI:IR_SH_LO];
    assign unused_rsv = ^ir[1:0];

    always_comb begin
        ctrl = CTRL_DEFAULT;
        cons = '0;
        unique case (state)
            S_EXEC: begin
                case (op)
                    OP_OPR, OP_OPI: begin
                        ctrl.a_sel   = ra;
                        ctrl.b_sel   = rb;
                        ctrl.d_sel   = rd;
                        ctrl.g_sel   = fn;
                        ctrl.load_en = onehot(rd);
                        if (op == OP_OPI) begin
                            ctrl.mb_sel = 1'b1;
                            cons        = k;
                        end
                    end
                    OP_SHF: begin
                        ctrl.b_sel   = rb;
                        ctrl.d_sel   = rd;
                        ctrl.h_sel   = sh;
                        ctrl.mf_sel  = 1'b1;
                        ctrl.load_en = onehot(rd);
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl.mem_req = 1'b1;
                ctrl.a_sel   = ra;
                ctrl.b_sel   = rb;
                ctrl.mem_we  = (op == OP_ST);
                // Load write-back; the top masks it outside the ack cycle.
                if (op == OP_LD) begin
                    ctrl.d_sel   = rd;
                    ctrl.md_sel  = 1'b1;
                    ctrl.load_en = onehot(rd);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/unidad_control.sv
// unidad_control: multi-cycle FSM sequencing the Procesador datapath.
// Ports: ROM (pc_out/instr_in), data mem handshake, control word, status.
module unidad_control
    import unidad_control_pkg::*;
#(
    parameter int m   = 8,
    parameter int PCW = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    output logic [PCW-1:0] pc_out,
    input  logic [15:0]    instr_in,
    input  logic [3:0]     Tags,
    output logic           mem_req,
    output logic           mem_we,
    input  logic           mem_ack,
    output logic [1:0]     A_sel,
    output logic [1:0]     B_sel,
    output logic [1:0]     D_sel,
    output logic [1:0]     H_sel,
    output logic [3:0]     G_sel,
    output logic           MB_sel,
    output logic           MD_sel,
    output logic           MF_sel,
    output logic [m-1:0]   Cons_IN,
    output logic [3:0]     Load_en,
    output logic           busy,
    output logic           halted,
    output logic           error
);

    state_t         state, state_n;
    logic [PCW-1:0] pc;
    logic [15:0]    ir;
    logic [m-1:0]   k;
    logic [3:0]     flags;
    logic           error_q, halted_q;
    opcode_t        op_in, op_ir;
    logic           taken;
    ctrl_t          ctrl, ctrl_g;
    logic [m-1:0]   cons;

    // FETCH decides on the word arriving from ROM, later states on IR.
    assign op_in = opcode_t'(instr_in[IR_OP_HI:IR_OP_LO]);
    assign op_ir = opcode_t'(ir[IR_OP_HI:IR_OP_LO]);
    assign taken = |(flags & ir[IR_FN_HI:IR_FN_LO]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (start) state_n = S_FETCH;
            S_FETCH: begin
                case (op_in)
                    OP_OPI, OP_JMP, OP_BRC: state_n = S_FETCH_K;
                    OP_LD, OP_ST:           state_n = S_MEM;
                    OP_HALT:                state_n = S_IDLE;
                    default:                state_n = S_EXEC;
                endcase
            end
            S_FETCH_K: state_n = (op_ir == OP_OPI) ? S_EXEC : S_FETCH;
            S_EXEC:    state_n = S_FETCH;
            S_MEM:     if (mem_ack) state_n = S_FETCH;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc       <= '0;
            ir       <= '0;
            k        <= '0;
            flags    <= '0;
            error_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (start) halted_q <= 1'b0;
                S_FETCH: begin
                    ir <= instr_in;
                    pc <= pc + PCW'(1);
                    if (is_illegal(instr_in[IR_OP_HI:IR_OP_LO]))
                        error_q <= 1'b1;
                    if (op_in == OP_HALT)
                        halted_q <= 1'b1;
                end
                S_FETCH_K: begin
                    k <= instr_in[m-1:0];
                    if (op_ir == OP_JMP || (op_ir == OP_BRC && taken))
                        pc <= instr_in[PCW-1:0];
                    else
                        pc <= pc + PCW'(1);
                end
                S_EXEC: begin
                    if (op_ir == OP_OPR || op_ir == OP_OPI ||
                        op_ir == OP_SHF)
                        flags <= Tags;
                end
                default: ;
            endcase
        end
    end

    decodificador_instr #(.m(m)) u_dec (
        .state (state),
        .ir    (ir),
        .k     (k),
        .ctrl  (ctrl),
        .cons  (cons)
    );

    // A load only writes back in the cycle memory acknowledges.
    always_comb begin
        ctrl_g = ctrl;
        if (state == S_MEM && !mem_ack) begin
            ctrl_g.load_en = '0;
            ctrl_g.md_sel  = 1'b0;
        end
    end

    assign pc_out  = pc;
    assign mem_req = ctrl_g.mem_req;
    assign mem_we  = ctrl_g.mem_we;
    assign A_sel   = ctrl_g.a_sel;
    assign B_sel   = ctrl_g.b_sel;
    assign D_sel   = ctrl_g.d_sel;
    assign H_sel   = ctrl_g.h_sel;
    assign G_sel   = ctrl_g.g_sel;
    assign MB_sel  = ctrl_g.mb_sel;
    assign MD_sel  = ctrl_g.md_sel;
    assign MF_sel  = ctrl_g.mf_sel;
    assign Cons_IN = cons;
    assign Load_en = ctrl_g.load_en;
    assign busy    = (state != S_IDLE);
    assign halted  = halted_q;
    assign error   = error_q;

endmodule

// File: tb/tb_unidad_control.sv
// tb_unidad_control: directed plan plus random programs scored against
// an instruction-level model of the control unit.
module tb_unidad_control;

    localparam int M   = 8;
    localparam int PCW = 8;

    logic           clock = 1'b0;
    logic           reset, start, mem_ack;
    logic [15:0]    instr_in;
    logic [3:0]     Tags;
    logic [PCW-1:0] pc_out;
    logic           mem_req, mem_we;
    logic [1:0]     A_sel, B_sel, D_sel, H_sel;
    logic [3:0]     G_sel, Load_en;
    logic           MB_sel, MD_sel, MF_sel;
    logic [M-1:0]   Cons_IN;
    logic           busy, halted, error;

    logic [15:0] rom [256];
    assign instr_in = rom[pc_out];

    always #5 clock = ~clock;

    unidad_control #(.m(M), .PCW(PCW)) dut (
        .clock(clock), .reset(reset), .start(start), .pc_out(pc_out),
        .instr_in(instr_in), .Tags(Tags), .mem_req(mem_req),
        .mem_we(mem_we), .mem_ack(mem_ack), .A_sel(A_sel),
        .B_sel(B_sel), .D_sel(D_sel), .H_sel(H_sel), .G_sel(G_sel),
        .MB_sel(MB_sel), .MD_sel(MD_sel), .MF_sel(MF_sel),
        .Cons_IN(Cons_IN), .Load_en(Load_en), .busy(busy),
        .halted(halted), .error(error)
    );

    typedef struct packed {
        logic [3:0] le;
        logic [1:0] a, b, d, h;
        logic [3:0] g;
        logic       mb, mf, md, req, we;
        logic [7:0] cons;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  sb_on = 0;
    bit  ack_fixed = 1;
    int  ack_wait_cfg = 0;
    int  wait_left = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic ev_t observe();
        ev_t o;
        o.le = Load_en; o.a = A_sel; o.b = B_sel; o.d = D_sel;
        o.h = H_sel; o.g = G_sel; o.mb = MB_sel; o.mf = MF_sel;
        o.md = MD_sel; o.req = mem_req; o.we = mem_we; o.cons = Cons_IN;
        return o;
    endfunction

    // Memory responder: ack after a chosen wait; noise on ack when idle.
    always @(posedge clock) begin
        #1;
        if (mem_req) begin
            if (wait_left <= 0) mem_ack = 1'b1;
            else begin
                mem_ack = 1'b0;
                wait_left--;
            end
        end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            wait_left = ack_fixed ? ack_wait_cfg : int'($urandom_range(0, 3));
        end
    end

    // Monitor: every register write or completed memory access is an event.
    always @(negedge clock) begin
        if (sb_on && !reset) begin
            if (Load_en != 4'b0 || (mem_req && mem_ack)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%h required=none",
                             observe());
                end else begin
                    chk("sb_event", observe(), exp_q.pop_front());
                end
            end else if (mem_req) begin
                chk("mem_wait_md", {31'b0, MD_sel}, 0);
            end else begin
                chk("quiet_outputs", observe(), 0);
            end
        end
    end

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < 2000; i++) begin
            if (!busy) break;
            @(negedge clock);
        end
        if (i == 2000) begin
            checks++;
            errors++;
            $display("FAIL %s actual=busy required=idle", nm);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Instruction-level model: walks the ROM, emits expected events.
    task automatic model_run(input logic [3:0] tg,
                             output logic [7:0] end_pc, output bit err);
        logic [7:0]  pc = 8'd0;
        logic [7:0]  pn;
        logic [3:0]  fl = 4'd0;
        logic [15:0] w, kw;
        logic [1:0]  rd, ra, rb;
        ev_t         e;
        err    = 0;
        end_pc = 8'd0;
        for (int n = 0; n < 300; n++) begin
            pn = pc + 8'd1;
            w  = rom[pc];
            kw = rom[pn];
            rd = w[11:10]; ra = w[9:8]; rb = w[7:6];
            e  = '0;
            case (w[15:12])
                4'h1, 4'h2: begin
                    e.le = 4'b0001 << rd; e.a = ra; e.b = rb; e.d = rd;
                    e.g = w[5:2];
                    if (w[15:12] == 4'h2) begin
                        e.mb = 1'b1; e.cons = kw[7:0]; pc = pc + 8'd2;
                    end else pc = pn;
                    exp_q.push_back(e);
                    fl = tg;
                end
                4'h3: begin
                    e.le = 4'b0001 << rd; e.b = rb; e.d = rd;
                    e.h = w[3:2]; e.mf = 1'b1;
                    exp_q.push_back(e);
                    fl = tg;
                    pc = pn;
                end
                4'h4, 4'h5: begin
                    e.req = 1'b1; e.a = ra; e.b = rb;
                    if (w[15:12] == 4'h4) begin
                        e.le = 4'b0001 << rd; e.d = rd; e.md = 1'b1;
                    end else e.we = 1'b1;
                    exp_q.push_back(e);
                    pc = pn;
                end
                4'h6: pc = kw[7:0];
                4'h7: pc = ((fl & w[5:2]) != 4'd0) ? kw[7:0] : pc + 8'd2;
                4'hF: begin
                    end_pc = pn;
                    return;
                end
                default: begin
                    if (w[15]) err = 1;
                    pc = pn;
                end
            endcase
        end
    endtask

    // Random program; branches only go forward so it always halts.
    task automatic gen_prog();
        int addr = 0;
        int n;
        int slot_addr[40];
        int kpos[$];
        int kslot[$];
        logic [3:0] op;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        n = $urandom_range(8, 30);
        for (int i = 0; i < n; i++) begin
            slot_addr[i] = addr;
            op = 4'($urandom_range(0, 8));
            if (op == 4'd8) op = 4'($urandom_range(8, 14));
            rom[addr] = {op, 12'($urandom)};
            addr++;
            if (op == 4'h2 || op == 4'h6 || op == 4'h7) begin
                rom[addr] = 16'($urandom);
                if (op != 4'h2) begin
                    kpos.push_back(addr);
                    kslot.push_back(i);
                end
                addr++;
            end
        end
        slot_addr[n] = addr;
        rom[addr] = 16'hF000;
        foreach (kpos[j]) begin
            int t;
            t = $urandom_range(kslot[j] + 1, n);
            rom[kpos[j]][7:0] = slot_addr[t][7:0];
        end
    endtask

    task automatic random_run();
        logic [7:0] end_pc;
        bit         err;
        gen_prog();
        Tags  = 4'($urandom);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        model_run(Tags, end_pc, err);
        @(negedge clock);
        sb_on = 1;
        @(negedge clock);
        do_start();
        wait_idle("rand_timeout");
        chk("rand_pc_end", {24'b0, pc_out}, {24'b0, end_pc});
        chk("rand_halted", {31'b0, halted}, 1);
        chk("rand_error", {31'b0, error}, {31'b0, err});
        chk("rand_queue_empty", exp_q.size(), 0);
        sb_on = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; Tags = 4'd0; mem_ack = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h16D4; rom[1] = 16'hF000;
        rom[2] = 16'h2108; rom[3] = 16'h00A5; rom[4] = 16'hF000;
        rom[5] = 16'h4C00; rom[6] = 16'hF000;
        rom[7] = 16'h16D4; rom[8] = 16'h7004; rom[9] = 16'h0040;
        rom[8'h40] = 16'hF000;
        rom[8'h41] = 16'h16D4; rom[8'h42] = 16'h7004;
        rom[8'h43] = 16'h0040; rom[8'h44] = 16'hF000;
        rom[8'h45] = 16'h9000; rom[8'h46] = 16'hF000;
        rom[8'h47] = 16'h5000;
        repeat (2) @(negedge clock);
        chk("rst_pc", {24'b0, pc_out}, 0);
        chk("rst_status", {29'b0, busy, halted, error}, 0);
        chk("rst_outputs", observe(), 0);
        reset = 1'b0;
        @(negedge clock);

        // OPR 0x16D4
        do_start();
        chk("opr_fetch_busy", {31'b0, busy}, 1);
        @(negedge clock);
        chk("opr_ctrl", {A_sel, B_sel, D_sel, G_sel, MB_sel, MF_sel,
                         MD_sel, Load_en},
            {2'd2, 2'd3, 2'd1, 4'd5, 3'b000, 4'b0010});
        chk("opr_pc", {24'b0, pc_out}, 1);
        @(negedge clock);
        chk("opr_two_cycles_pc", {24'b0, pc_out, busy, Load_en},
            {24'd1, 1'b1, 4'b0});
        @(negedge clock);
        chk("halt_status", {30'b0, busy, halted}, 1);
        chk("halt_pc", {24'b0, pc_out}, 2);

        // OPI 0x2108 / 0x00A5, resumes after HALT
        do_start();
        chk("start_clears_halted", {31'b0, halted}, 0);
        chk("opi_fetch_pc", {24'b0, pc_out}, 2);
        @(negedge clock);
        chk("opi_fetchk_quiet", {28'b0, Load_en}, 0);
        @(negedge clock);
        chk("opi_ctrl", {Cons_IN, MB_sel, G_sel, Load_en, A_sel},
            {8'hA5, 1'b1, 4'd2, 4'b0001, 2'd1});
        chk("opi_pc", {24'b0, pc_out}, 4);
        wait_idle("opi_halt_timeout");

        // LD 0x4C00, ack in third MEM cycle
        ack_wait_cfg = 2;
        do_start();
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk("ld_wait", {mem_req, mem_we, Load_en, MD_sel},
                {1'b1, 1'b0, 4'b0, 1'b0});
        end
        @(negedge clock);
        chk("ld_ack_cycle", {mem_req, mem_we, Load_en, MD_sel, D_sel},
            {1'b1, 1'b0, 4'b1000, 1'b1, 2'd3});
        @(negedge clock);
        chk("ld_done", {mem_req, Load_en, MD_sel}, 0);
        chk("ld_pc", {24'b0, pc_out}, 6);
        wait_idle("ld_halt_timeout");

        // BRC taken after OPR with Z set
        Tags = 4'b0001;
        do_start();
        repeat (4) @(negedge clock);
        chk("brc_taken_pc", {24'b0, pc_out}, 32'h40);
        wait_idle("brc_t_timeout");

        // BRC not taken after OPR clearing flags
        Tags = 4'b0000;
        do_start();
        repeat (4) @(negedge clock);
        chk("brc_not_taken_pc", {24'b0, pc_out}, 32'h44);
        wait_idle("brc_nt_timeout");

        // Illegal opcode
        do_start();
        chk("illegal_before", {31'b0, error}, 0);
        @(negedge clock);
        chk("illegal_error", {31'b0, error}, 1);
        chk("illegal_no_load", {28'b0, Load_en}, 0);
        chk("illegal_pc", {24'b0, pc_out}, 32'h46);
        wait_idle("illegal_timeout");

        // Reset during ST with mem_req high
        ack_wait_cfg = 10;
        do_start();
        @(negedge clock);
        chk("st_mem", {30'b0, mem_req, mem_we}, 3);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_drop", {mem_req, Load_en, busy, pc_out}, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_stay_idle", {busy, pc_out}, 0);

        // PC wrap: JMP to 0xFD, HALT at 0xFF
        rom[0] = 16'h6000; rom[1] = 16'h00FD;
        rom[8'hFD] = 16'h0000; rom[8'hFE] = 16'h0000;
        rom[8'hFF] = 16'hF000;
        ack_fixed = 0;
        do_start();
        wait_idle("wrap_timeout");
        chk("wrap_pc", {24'b0, pc_out}, 0);
        chk("wrap_halted", {31'b0, halted}, 1);

        repeat (25) random_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
